// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage access unit: DMType codes, FSM states
// and the alignment helpers used by the sequencer.
package mem_pkg;

   localparam int AW_DEF = 32;
   localparam int DW_DEF = 32;

   localparam logic [2:0] DM_B  = 3'b000;
   localparam logic [2:0] DM_H  = 3'b001;
   localparam logic [2:0] DM_W  = 3'b010;
   localparam logic [2:0] DM_BU = 3'b100;
   localparam logic [2:0] DM_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LD_HI   = 2'd1,
      ST_BYTE = 2'd2
   } state_t;

   function automatic logic is_valid_type(input logic [2:0] t);
      case (t)
         DM_B, DM_H, DM_W, DM_BU, DM_HU: return 1'b1;
         default:                        return 1'b0;
      endcase
   endfunction

   // Bytes can never straddle a word, so only halves and words are checked.
   function automatic logic is_misaligned(input logic [2:0] t, input logic [1:0] off);
      case (t)
         DM_H, DM_HU: return off[0];
         DM_W:        return off != 2'b00;
         default:     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundle of the pipeline request/response handshake and the data-memory bus.
// slave = the access unit, master = pipeline plus data memory.
interface mem_access_unit_if #(
   parameter int AW = 32,
   parameter int DW = 32
);

   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [2:0]    req_type;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;

   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;

   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_din;
   logic          dm_we;
   logic [2:0]    dm_type;
   logic [DW-1:0] dm_dout;

   modport slave (
      input  req_valid, req_we, req_type, req_addr, req_wdata, dm_dout,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
             dm_addr, dm_din, dm_we, dm_type
   );

   modport master (
      output req_valid, req_we, req_type, req_addr, req_wdata, dm_dout,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
             dm_addr, dm_din, dm_we, dm_type
   );

endinterface

// File: rtl/mem_access_unit_load_align.sv
// Combinational load aligner: shifts the {hi, lo} word pair down by the byte
// offset and extends the selected byte/half/word according to DMType.
module load_align
   import mem_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [DW-1:0] hi_i,
   input  logic [DW-1:0] lo_i,
   input  logic [1:0]    off_i,
   input  logic [2:0]    type_i,
   output logic [DW-1:0] data_o
);

   logic [DW-1:0] shifted;

   assign shifted = DW'({hi_i, lo_i} >> (8 * off_i));

   // Re-extending an already extended dm word is harmless, so the aligned path can share this.
   always_comb begin
      data_o = '0;
      case (type_i)
         DM_B:    data_o = {{(DW-8){shifted[7]}}, shifted[7:0]};
         DM_BU:   data_o = {{(DW-8){1'b0}}, shifted[7:0]};
         DM_H:    data_o = {{(DW-16){shifted[15]}}, shifted[15:0]};
         DM_HU:   data_o = {{(DW-16){1'b0}}, shifted[15:0]};
         DM_W:    data_o = shifted;
         default: data_o = '0;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer in front of the data memory; splits misaligned
// accesses into aligned dm operations. Define MISALIGN_TRAP_EN to reject them instead.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input logic              clk,
   input logic              rstn,
   mem_access_unit_if.slave bus
);

   state_t        state_q;
   logic          rsp_valid_q;
   logic          rsp_err_q;
   logic [DW-1:0] rsp_rdata_q;

`ifndef MISALIGN_TRAP_EN
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] lo_q;
   logic [2:0]    type_q;
   logic [1:0]    idx_q;
   logic [1:0]    lastIdx_q;
`endif

   logic          reqTypeOk;
   logic          reqMis;
   logic [AW-1:0] dmAddr;
   logic [DW-1:0] dmDin;
   logic          dmWe;
   logic [2:0]    dmType;
   logic [DW-1:0] alignHi;
   logic [DW-1:0] alignLo;
   logic [1:0]    alignOff;
   logic [2:0]    alignType;
   logic [DW-1:0] rdata_d;

   assign reqTypeOk = is_valid_type(bus.req_type);
   assign reqMis    = is_misaligned(bus.req_type, bus.req_addr[1:0]);

   // Aligned loads see {0, dm word} at offset 0; the second split read merges with lo_q.
   always_comb begin
      alignHi   = '0;
      alignLo   = bus.dm_dout;
      alignOff  = 2'b00;
      alignType = bus.req_type;
`ifndef MISALIGN_TRAP_EN
      if (state_q == LD_HI) begin
         alignHi   = bus.dm_dout;
         alignLo   = lo_q;
         alignOff  = addr_q[1:0];
         alignType = type_q;
      end
`endif
   end

   load_align #(.DW(DW)) u_load_align (
      .hi_i   (alignHi),
      .lo_i   (alignLo),
      .off_i  (alignOff),
      .type_i (alignType),
      .data_o (rdata_d)
   );

   always_comb begin
      dmAddr = bus.req_addr;
      dmDin  = '0;
      dmWe   = 1'b0;
      dmType = DM_W;
      case (state_q)
         IDLE: begin
            if (bus.req_valid && reqTypeOk) begin
               if (!reqMis) begin
                  dmDin  = bus.req_wdata;
                  dmWe   = bus.req_we;
                  dmType = bus.req_type;
               end
`ifndef MISALIGN_TRAP_EN
               else if (!bus.req_we) begin
                  dmAddr = {bus.req_addr[AW-1:2], 2'b00};
               end else begin
                  dmDin  = {{(DW-8){1'b0}}, bus.req_wdata[7:0]};
                  dmWe   = 1'b1;
                  dmType = DM_B;
               end
`endif
            end
         end
`ifndef MISALIGN_TRAP_EN
         // Full-width add: the dm only decodes addr[8:2], so the top word wraps to word 0.
         LD_HI: begin
            dmAddr = {addr_q[AW-1:2], 2'b00} + AW'(4);
         end
         ST_BYTE: begin
            dmAddr = addr_q + AW'(idx_q);
            dmDin  = {{(DW-8){1'b0}}, wdata_q[8*idx_q +: 8]};
            dmWe   = 1'b1;
            dmType = DM_B;
         end
`endif
         default: ;
      endcase
   end

   assign bus.dm_addr   = dmAddr;
   assign bus.dm_din    = dmDin;
   assign bus.dm_we     = dmWe & rstn;
   assign bus.dm_type   = dmType;
   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_rdata_q;

   // rsp_rdata holds its last value between pulses; only rsp_valid qualifies it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
`ifndef MISALIGN_TRAP_EN
         addr_q      <= '0;
         wdata_q     <= '0;
         lo_q        <= '0;
         type_q      <= DM_W;
         idx_q       <= 2'd0;
         lastIdx_q   <= 2'd0;
`endif
      end else begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  if (!reqTypeOk) begin
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_rdata_q <= '0;
                  end else if (!reqMis) begin
                     rsp_valid_q <= 1'b1;
                     rsp_rdata_q <= bus.req_we ? '0 : rdata_d;
                  end else begin
`ifdef MISALIGN_TRAP_EN
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_rdata_q <= '0;
`else
                     addr_q  <= bus.req_addr;
                     wdata_q <= bus.req_wdata;
                     type_q  <= bus.req_type;
                     if (!bus.req_we) begin
                        lo_q    <= bus.dm_dout;
                        state_q <= LD_HI;
                     end else begin
                        idx_q     <= 2'd1;
                        lastIdx_q <= (bus.req_type == DM_W) ? 2'd3 : 2'd1;
                        state_q   <= ST_BYTE;
                     end
`endif
                  end
               end
            end
`ifndef MISALIGN_TRAP_EN
            LD_HI: begin
               rsp_valid_q <= 1'b1;
               rsp_rdata_q <= rdata_d;
               state_q     <= IDLE;
            end
            ST_BYTE: begin
               if (idx_q == lastIdx_q) begin
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= '0;
                  state_q     <= IDLE;
               end else begin
                  idx_q <= idx_q + 2'd1;
               end
            end
`endif
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
